// File: rtl/queue_sched_if.sv
// rtl/queue_sched_if.sv - producer/consumer/queue signal bundle for queue_sched
//
// Purpose: groups every handshake and data signal around the scheduler so the
// block and its environment connect through one port.
//
// Signals:
//   req_valid [NREQ]        producer i has a word
//   req_data  [NREQ*WIDTH]  producer i word at [i*WIDTH +: WIDTH]
//   req_ready [NREQ]        one-hot enqueue grant
//   q_enqueue, q_dequeue    single-op strobes to the shared queue
//   q_d       [WIDTH]       write data to the queue
//   q_q       [WIDTH]       read data from the queue, valid the cycle after q_dequeue
//   out_valid, out_data     registered consumer output
//   out_ready               consumer accepts
//   count     [DEPTH+1]     entries held in the queue
//
// Modports: slave = the scheduler, master = the environment driving it.
interface queue_sched_if #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 7,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  q_enqueue;
  logic                  q_dequeue;
  logic [WIDTH-1:0]      q_d;
  logic [WIDTH-1:0]      q_q;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_ready;
  logic [DEPTH:0]        count;

  modport slave (
    input  req_valid, req_data, q_q, out_ready,
    output req_ready, q_enqueue, q_dequeue, q_d, out_valid, out_data, count
  );

  modport master (
    output req_valid, req_data, q_q, out_ready,
    input  req_ready, q_enqueue, q_dequeue, q_d, out_valid, out_data, count
  );
endinterface

// File: rtl/queue_sched.sv
// rtl/queue_sched.sv - round-robin enqueue / registered dequeue scheduler for one shared queue
//
// Purpose: lets NREQ producers and one consumer share a queue that services a
// single operation per cycle. Producers are granted round-robin; the consumer
// is fed through a registered valid/ready stage. Occupancy is tracked here and
// the queue's own full/empty flags are not needed.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; the queue shares this reset
//   bus    queue_sched_if.slave (producer, queue and consumer signals)
module queue_sched #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 7,
  parameter int NREQ  = 4
) (
  input logic          clk,
  input logic          reset,
  queue_sched_if.slave bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    OP_ENQ = 1'b0,
    OP_DEQ = 1'b1
  } op_e;

  logic [DEPTH:0]   count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             inflight_q, inflight_d;
  op_e              last_op_q, last_op_d;
  logic [GW-1:0]    last_gnt_q, last_gnt_d;

  logic             any_valid;
  logic             queue_full;
  logic             enq_cand;
  logic             deq_cand;
  logic             issue_enq;
  logic             issue_deq;
  logic             gnt_found;
  int               scan_idx;
  logic [GW-1:0]    gnt_idx;
  logic [NREQ-1:0]  gnt_oh;
  logic [WIDTH-1:0] gnt_data;

  // Round-robin search: first valid producer after the last granted one.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = last_gnt_q;
    scan_idx  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = (int'(last_gnt_q) + k) % NREQ;
      if (!gnt_found && bus.req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = GW'(scan_idx);
      end
    end
  end

  assign gnt_data = bus.req_data[gnt_idx*WIDTH +: WIDTH];

  // count never exceeds 2^DEPTH, so its MSB alone marks the full state.
  assign any_valid  = |bus.req_valid;
  assign queue_full = count_q[DEPTH];

  // Candidates are suppressed during reset so no strobe reaches the queue
  // while it is being cleared. DEQ waits for the previous read to land and
  // for the output register to be free (or freeing this cycle).
  assign enq_cand = !reset && any_valid && !queue_full;
  assign deq_cand = !reset && (count_q != '0) && !inflight_q &&
                    (!out_valid_q || bus.out_ready);

  // Under contention the op that did not go last wins, giving strict
  // alternation; the two issue terms are mutually exclusive by construction.
  assign issue_enq = enq_cand && (!deq_cand || (last_op_q == OP_DEQ));
  assign issue_deq = deq_cand && (!enq_cand || (last_op_q == OP_ENQ));

  always_comb begin
    gnt_oh = '0;
    if (issue_enq) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

  assign bus.req_ready = gnt_oh;
  assign bus.q_enqueue = issue_enq;
  assign bus.q_dequeue = issue_deq;
  assign bus.q_d       = gnt_data;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.count     = count_q;

  // Next-state logic.
  always_comb begin
    count_d     = count_q;
    last_op_d   = last_op_q;
    last_gnt_d  = last_gnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    // A dequeue cannot issue while one is in flight, so inflight simply
    // mirrors last cycle's dequeue strobe.
    inflight_d  = issue_deq;

    if (issue_enq) begin
      count_d    = count_q + 1'b1;
      last_op_d  = OP_ENQ;
      last_gnt_d = gnt_idx;
    end else if (issue_deq) begin
      count_d   = count_q - 1'b1;
      last_op_d = OP_DEQ;
    end

    // A landing word always takes the register, even if the consumer drains
    // the old one in the same cycle.
    if (inflight_q) begin
      out_data_d  = bus.q_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      inflight_q  <= 1'b0;
      last_op_q   <= OP_DEQ;
      last_gnt_q  <= GW'(NREQ - 1);
    end else begin
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      inflight_q  <= inflight_d;
      last_op_q   <= last_op_d;
      last_gnt_q  <= last_gnt_d;
    end
  end
endmodule

// File: tb/tb_queue_sched.sv
// tb/tb_queue_sched.sv - directed self-checking bench for queue_sched
module tb_queue_sched;
  localparam int WIDTH = 11;
  localparam int DEPTH = 7;
  localparam int NREQ  = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_chk;
  int   n_fail;

  always #5 clk = ~clk;

  queue_sched_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) bus ();

  queue_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [WIDTH-1:0] mem [0:(1<<DEPTH)-1];
  logic [DEPTH-1:0] wptr;
  logic [DEPTH-1:0] rptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      bus.q_q <= '0;
    end else if (bus.q_enqueue) begin
      mem[wptr] <= bus.q_d;
      wptr      <= wptr + 1'b1;
    end else if (bus.q_dequeue) begin
      bus.q_q <= mem[rptr];
      rptr    <= rptr + 1'b1;
    end
  end

  logic [WIDTH-1:0] dv [4];
  int               word;

  logic [3:0] rr_rdy [7] = '{4'b0001, 4'b0000, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  int         rr_src [7] = '{0, -1, 1, 2, 3, 0, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
    check("enq_deq_mutex", bus.q_enqueue & bus.q_dequeue, 1'b0);
  endtask

  task automatic drive_data();
    bus.req_data = {dv[3], dv[2], dv[1], dv[0]};
  endtask

  task automatic do_reset();
    tick();
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
    settle();
    tick();
    reset = 1'b0;
    settle();
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    dv[0] = 11'h100; dv[1] = 11'h111; dv[2] = 11'h122; dv[3] = 11'h133;

    tick();
    bus.req_valid = 4'b1111;
    drive_data();
    settle();
    check("rst_req_ready", bus.req_ready, 4'b0000);
    check("rst_q_enqueue", bus.q_enqueue, 1'b0);
    check("rst_q_dequeue", bus.q_dequeue, 1'b0);
    tick();
    reset         = 1'b0;
    bus.req_valid = '0;
    settle();
    check("rst_count", bus.count, 8'd0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 11'h000);

    word = 1;
    for (int c = 0; c < 130; c++) begin
      tick();
      bus.req_valid = 4'b0001;
      dv[0] = WIDTH'(word);
      drive_data();
      settle();
      check("fill_count", bus.count, (c == 0) ? 0 : (c == 1) ? 1 : c - 2);
      if (c == 1) begin
        check("fill_rdy_steal", bus.req_ready, 4'b0000);
        check("fill_deq_steal", bus.q_dequeue, 1'b1);
      end else begin
        check("fill_rdy", bus.req_ready, 4'b0001);
        check("fill_q_d", bus.q_d, (c == 0) ? 1 : c);
      end
      if (bus.req_ready[0]) word++;
    end

    tick();
    bus.req_valid = 4'b1111;
    settle();
    check("full_count", bus.count, 8'd128);
    check("full_rdy", bus.req_ready, 4'b0000);
    check("full_out_valid", bus.out_valid, 1'b1);
    check("full_out_data", bus.out_data, 11'h001);
    check("full_no_deq", bus.q_dequeue, 1'b0);

    for (int t = 0; t <= 256; t++) begin
      tick();
      bus.req_valid = '0;
      bus.out_ready = 1'b1;
      settle();
      check("drain_count", bus.count, 128 - (t + 1) / 2);
      check("drain_out_valid", bus.out_valid, (t % 2 == 0) ? 1'b1 : 1'b0);
      check("drain_deq", bus.q_dequeue, ((t % 2 == 0) && (t < 256)) ? 1'b1 : 1'b0);
      if (t % 2 == 0) check("drain_out_data", bus.out_data, t / 2 + 1);
    end
    tick();
    bus.out_ready = 1'b0;
    settle();
    check("drained_count", bus.count, 8'd0);
    check("drained_out_valid", bus.out_valid, 1'b0);

    do_reset();
    dv[0] = 11'h100; dv[1] = 11'h111; dv[2] = 11'h122; dv[3] = 11'h133;
    for (int c = 0; c < 7; c++) begin
      tick();
      bus.req_valid = 4'b1111;
      bus.out_ready = 1'b0;
      drive_data();
      settle();
      check("rr_rdy", bus.req_ready, rr_rdy[c]);
      check("rr_deq", bus.q_dequeue, (c == 1) ? 1'b1 : 1'b0);
      if (rr_src[c] >= 0) check("rr_q_d", bus.q_d, dv[rr_src[c]]);
      if (c == 3) check("rr_out_data", bus.out_data, 11'h100);
    end

    for (int k = 0; k < 8; k++) begin
      tick();
      bus.req_valid = 4'b0001;
      bus.out_ready = 1'b1;
      settle();
      check("alt_count", bus.count, (k % 2 == 0) ? 5 : 4);
      check("alt_deq", bus.q_dequeue, (k % 2 == 0) ? 1'b1 : 1'b0);
      check("alt_enq", bus.q_enqueue, (k % 2 == 1) ? 1'b1 : 1'b0);
      check("alt_rdy", bus.req_ready, (k % 2 == 1) ? 4'b0001 : 4'b0000);
      if (k == 0) check("alt_out0", bus.out_data, 11'h100);
      if (k == 2) check("alt_out2", bus.out_data, 11'h111);
      if (k == 4) check("alt_out4", bus.out_data, 11'h122);
      if (k == 6) check("alt_out6", bus.out_data, 11'h133);
    end

    do_reset();
    tick();
    bus.req_valid = 4'b0001;
    dv[0] = 11'h3AA;
    drive_data();
    settle();
    check("bp_enq_a", bus.req_ready, 4'b0001);
    tick();
    dv[0] = 11'h155;
    drive_data();
    settle();
    check("bp_steal_rdy", bus.req_ready, 4'b0000);
    check("bp_steal_deq", bus.q_dequeue, 1'b1);
    tick();
    settle();
    check("bp_enq_b", bus.req_ready, 4'b0001);
    for (int b = 0; b < 10; b++) begin
      tick();
      bus.req_valid = '0;
      settle();
      check("bp_hold_valid", bus.out_valid, 1'b1);
      check("bp_hold_data", bus.out_data, 11'h3AA);
      check("bp_hold_nodeq", bus.q_dequeue, 1'b0);
    end
    tick();
    bus.out_ready = 1'b1;
    settle();
    check("bp_release_deq", bus.q_dequeue, 1'b1);
    tick();
    settle();
    check("bp_gap_valid", bus.out_valid, 1'b0);
    tick();
    settle();
    check("bp_next_valid", bus.out_valid, 1'b1);
    check("bp_next_data", bus.out_data, 11'h155);

    for (int e = 0; e < 5; e++) begin
      tick();
      settle();
      check("empty_nodeq", bus.q_dequeue, 1'b0);
      check("empty_out_valid", bus.out_valid, 1'b0);
      check("empty_count", bus.count, 8'd0);
    end

    tick();
    bus.req_valid = 4'b0001;
    bus.out_ready = 1'b0;
    dv[0] = 11'h2C3;
    drive_data();
    settle();
    check("rm_enq", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    settle();
    check("rm_deq", bus.q_dequeue, 1'b1);
    tick();
    reset         = 1'b1;
    bus.req_valid = 4'b1111;
    dv[0] = 11'h100;
    drive_data();
    settle();
    check("rm_rst_rdy", bus.req_ready, 4'b0000);
    check("rm_rst_deq", bus.q_dequeue, 1'b0);
    tick();
    reset = 1'b0;
    settle();
    check("rm_out_valid", bus.out_valid, 1'b0);
    check("rm_out_data", bus.out_data, 11'h000);
    check("rm_count", bus.count, 8'd0);
    check("rm_first_gnt", bus.req_ready, 4'b0001);
    check("rm_first_q_d", bus.q_d, 11'h100);
    tick();
    settle();
    check("rm_contend_deq", bus.q_dequeue, 1'b1);
    tick();
    settle();
    check("rm_next_gnt", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    settle();
    check("rm_land_valid", bus.out_valid, 1'b1);
    check("rm_land_data", bus.out_data, 11'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
